tx_uart: RTL and testbench

- UART transmitter: pulls bytes from an upstream TX FIFO (first-word-fall-through not required; one-cycle read latency) and serialises them as 8N1 frames on SerialDataOut.
- Sits between the TX FIFO and the board TX pin; 50 MHz system clock, 115200 baud by default.

---
 rtl/tx_uart.sv | 117 +++++++++++
 tb/tb_tx_uart.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_uart.sv
`timescale 1ns/1ps
// tx_uart: 8N1 UART transmitter fed from a TX FIFO with one-cycle read latency.
// Each frame is a start bit, eight data bits LSB first and a stop bit, each CLKS_PER_BIT clocks long.
module tx_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clk,
    input  logic       RstB,
    input  logic       TxFfEmpty,
    input  logic [7:0] TxFfRdData,
    output logic       TxFfRdEn,
    output logic       SerialDataOut
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        START,
        DATA,
        STOP
    } txStateT;

    txStateT           state, stateNext;
    logic [BAUD_W-1:0] baudCnt, baudCntNext;
    logic [2:0]        bitCnt, bitCntNext;
    logic [7:0]        shiftReg, shiftRegNext;
    logic              rdEnNext;
    logic              serialNext;
    logic              bitDone;

    assign bitDone = (baudCnt == BAUD_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext    = state;
        baudCntNext  = baudCnt + BAUD_W'(1);
        bitCntNext   = bitCnt;
        shiftRegNext = shiftReg;
        serialNext   = SerialDataOut;
        rdEnNext     = 1'b0;

        unique case (state)
            IDLE: begin
                baudCntNext = '0;
                serialNext  = 1'b1;
                if (!TxFfEmpty) begin
                    stateNext = READ;
                    rdEnNext  = 1'b1;
                end
            end
            READ: begin
                baudCntNext = '0;
                stateNext   = WAIT;
            end
            WAIT: begin
                // Read data is valid now, one cycle after the strobe; the start bit begins here too.
                baudCntNext  = '0;
                stateNext    = START;
                shiftRegNext = TxFfRdData;
                serialNext   = 1'b0;
            end
            START: begin
                if (bitDone) begin
                    baudCntNext  = '0;
                    stateNext    = DATA;
                    bitCntNext   = '0;
                    serialNext   = shiftReg[0];
                    shiftRegNext = shiftReg >> 1;
                end
            end
            DATA: begin
                if (bitDone) begin
                    baudCntNext = '0;
                    if (bitCnt == 3'd7) begin
                        stateNext  = STOP;
                        serialNext = 1'b1;
                    end else begin
                        bitCntNext   = bitCnt + 3'd1;
                        serialNext   = shiftReg[0];
                        shiftRegNext = shiftReg >> 1;
                    end
                end
            end
            STOP: begin
                if (bitDone) begin
                    baudCntNext = '0;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (RstB) begin
            state         <= IDLE;
            baudCnt       <= '0;
            bitCnt        <= '0;
            shiftReg      <= '0;
            TxFfRdEn      <= 1'b0;
            SerialDataOut <= 1'b1;
        end else begin
            state         <= stateNext;
            baudCnt       <= baudCntNext;
            bitCnt        <= bitCntNext;
            shiftReg      <= shiftRegNext;
            TxFfRdEn      <= rdEnNext;
            SerialDataOut <= serialNext;
        end
    end

endmodule

// File: tb/tb_tx_uart.sv
`timescale 1ns/1ps
// tb_tx_uart: FIFO model plus a line-level frame checker that rebuilds each expected
// 10-bit waveform from the byte and compares it sample by sample.
module tb_tx_uart;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;

    logic       Clk = 1'b0;
    logic       RstB;
    logic       TxFfEmpty;
    logic [7:0] TxFfRdData;
    logic       TxFfRdEn;
    logic       SerialDataOut;

    always #5 Clk = ~Clk;

    tx_uart #(.CLKS_PER_BIT(CPB)) dut (
        .Clk          (Clk),
        .RstB         (RstB),
        .TxFfEmpty    (TxFfEmpty),
        .TxFfRdData   (TxFfRdData),
        .TxFfRdEn     (TxFfRdEn),
        .SerialDataOut(SerialDataOut)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Cycle count and reset as seen at each rising edge
    int cyc       = 0;
    bit rstAtEdge = 1'b0;
    initial forever begin
        @(posedge Clk);
        cyc++;
        rstAtEdge = RstB;
    end

    // Upstream FIFO model: data appears only in the cycle after the read strobe, garbage otherwise
    logic [7:0] fifoQ[$];
    bit         manualEmpty = 1'b0;
    bit         manualVal   = 1'b1;
    int         underflow   = 0;
    initial begin
        bit         popPending;
        logic [7:0] popData;
        popPending = 1'b0;
        popData    = '0;
        TxFfEmpty  = 1'b1;
        TxFfRdData = '0;
        forever begin
            @(negedge Clk);
            if (popPending) begin
                TxFfRdData = popData;
                popPending = 1'b0;
            end else begin
                TxFfRdData = 8'($urandom);
            end
            if (TxFfRdEn === 1'b1) begin
                if (fifoQ.size() > 0) popData = fifoQ.pop_front();
                else begin
                    popData = 8'($urandom);
                    underflow++;
                end
                popPending = 1'b1;
            end
            TxFfEmpty = manualEmpty ? manualVal : (fifoQ.size() == 0);
        end
    end

    // Line monitor / reference model
    logic [7:0] expQ[$];
    int         gapQ[$];
    int         framesDone    = 0;
    int         framesStarted = 0;
    int         rdCount       = 0;
    int         lastRdCyc     = -100;
    int         lastEnd       = -100000;
    int         rstLineBad    = 0;
    int         rstRdBad      = 0;
    initial begin : monitor_p
        bit         inFrame;
        int         pos, bad, startCyc;
        logic [7:0] dec, expByte;
        logic [9:0] wave;
        inFrame = 1'b0; pos = 0; bad = 0; startCyc = 0;
        dec = '0; expByte = '0; wave = '1;
        forever begin
            @(negedge Clk);
            if (TxFfRdEn === 1'b1) begin
                rdCount++;
                lastRdCyc = cyc;
            end
            if (rstAtEdge) begin
                if (SerialDataOut !== 1'b1) rstLineBad++;
                if (TxFfRdEn !== 1'b0) rstRdBad++;
                inFrame = 1'b0;
            end else begin
                if (!inFrame && SerialDataOut === 1'b0) begin
                    inFrame  = 1'b1;
                    pos      = 0;
                    bad      = 0;
                    dec      = '0;
                    startCyc = cyc;
                    framesStarted++;
                    check("start_latency", cyc - lastRdCyc, 2);
                    gapQ.push_back(cyc - lastEnd);
                    if (expQ.size() > 0) expByte = expQ.pop_front();
                    else begin
                        check("unexpected_frame", framesStarted, framesDone);
                        expByte = '0;
                    end
                    wave = {1'b1, expByte, 1'b0};
                end
                if (inFrame) begin
                    if (SerialDataOut !== wave[pos / CPB]) bad++;
                    if (pos % CPB == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8)
                        dec[pos / CPB - 1] = SerialDataOut;
                    pos++;
                    if (pos == FRAME) begin
                        check("frame_byte", dec, expByte);
                        check("frame_shape_errs", bad, 0);
                        inFrame = 1'b0;
                        framesDone++;
                        lastEnd = startCyc + FRAME;
                    end
                end
            end
        end
    end

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (framesDone < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check("frames_done", framesDone, target);
    endtask

    task automatic idleCheck(input string tag, input int n);
        int fs = framesStarted;
        int rd = rdCount;
        repeat (n) @(negedge Clk);
        check({tag, "_new_frames"}, framesStarted - fs, 0);
        check({tag, "_new_rden"}, rdCount - rd, 0);
        check({tag, "_line"}, SerialDataOut, 1);
    endtask

    task automatic sendQueued(input logic [7:0] b);
        fifoQ.push_back(b);
        expQ.push_back(b);
    endtask

    initial begin : watchdog_p
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main_p
        int         rd0, fs0, n;
        logic [7:0] b;
        logic [7:0] pulseBytes[3];
        RstB        = 1'b1;
        manualEmpty = 1'b1;
        manualVal   = 1'b0;

        // Reset with Empty low: line high, no reads
        repeat (5) @(negedge Clk);
        check("rst_line_bad", rstLineBad, 0);
        check("rst_rden_bad", rstRdBad, 0);
        check("rst_rdcount", rdCount, 0);
        check("rst_line_now", SerialDataOut, 1);
        manualVal = 1'b1;
        @(negedge Clk);
        RstB = 1'b0;
        idleCheck("post_rst_idle", 10);
        manualEmpty = 1'b0;

        // Single byte
        rd0 = rdCount;
        sendQueued(8'hA5);
        waitFrames(framesDone + 1, FRAME + 100);
        check("single_rdcount", rdCount - rd0, 1);

        // Streaming three bytes with Empty held low
        gapQ.delete();
        rd0 = rdCount;
        sendQueued(8'hA5);
        sendQueued(8'h00);
        sendQueued(8'hFF);
        waitFrames(framesDone + 3, 3 * FRAME + 100);
        check("stream_rdcount", rdCount - rd0, 3);
        check("stream_frames", gapQ.size(), 3);
        for (int i = 1; i < gapQ.size(); i++) check("stream_gap_le3", int'(gapQ[i] <= 3), 1);
        idleCheck("stream_idle", 20);

        // Short Empty pulses, one frame each
        pulseBytes[0] = 8'hA5;
        pulseBytes[1] = 8'h00;
        pulseBytes[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            manualEmpty = 1'b1;
            manualVal   = 1'b1;
            rd0         = rdCount;
            sendQueued(pulseBytes[i]);
            @(negedge Clk);
            manualVal = 1'b0;
            repeat (3) @(negedge Clk);
            manualVal = 1'b1;
            waitFrames(framesDone + 1, FRAME + 100);
            check("pulse_rdcount", rdCount - rd0, 1);
            idleCheck("pulse_idle", 300);
        end

        // Empty rises right after the read strobe
        manualEmpty = 1'b1;
        manualVal   = 1'b0;
        rd0         = rdCount;
        sendQueued(8'($urandom));
        n = 0;
        while (rdCount == rd0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        manualVal = 1'b1;
        waitFrames(framesDone + 1, FRAME + 100);
        check("emptyrise_rdcount", rdCount - rd0, 1);
        idleCheck("emptyrise_idle", 50);
        manualEmpty = 1'b0;

        // Reset during data bit 3 (chosen as 0 so the forced high is visible)
        rd0 = rdCount;
        fs0 = framesStarted;
        b   = 8'($urandom) & 8'hF7;
        sendQueued(b);
        n = 0;
        while (framesStarted == fs0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("midrst_frame_started", framesStarted - fs0, 1);
        repeat (4 * CPB + CPB / 2) @(negedge Clk);
        check("midrst_bit3_low", SerialDataOut, 0);
        RstB = 1'b1;
        sendQueued(8'($urandom));
        @(negedge Clk);
        check("midrst_line_next_edge", SerialDataOut, 1);
        repeat (4) @(negedge Clk);
        check("midrst_line_bad", rstLineBad, 0);
        check("midrst_rden_bad", rstRdBad, 0);
        check("midrst_rd_during_rst", rdCount - rd0, 1);
        RstB = 1'b0;
        waitFrames(framesDone + 1, FRAME + 100);
        check("midrst_rdcount", rdCount - rd0, 2);

        // Random bytes with random push spacing
        rd0 = rdCount;
        for (int i = 0; i < 3; i++) begin
            sendQueued(8'($urandom));
            repeat ($urandom_range(0, 50)) @(negedge Clk);
        end
        waitFrames(framesDone + 3, 3 * FRAME + 200);
        check("rand_rdcount", rdCount - rd0, 3);
        idleCheck("final_idle", 20);

        check("fifo_underflow", underflow, 0);
        check("exp_queue_left", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
